// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and level helpers for the hue sequencer
// Purpose: sequencer state enum, hue phase enum, step size / peak level helpers.
// Ports: none (package).
package pwm_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4,
    PH_5 = 3'd5
  } phase_t;

  // Largest per-step increment that keeps a full phase ramp within the pwm range.
  function automatic int calc_step_size(input int pwm_interval, input int steps_per_phase);
    return (pwm_interval - 1) / steps_per_phase;
  endfunction

  // Peak channel level: exactly where a full ramp of STEP_SIZE increments lands.
  function automatic int calc_level_max(input int pwm_interval, input int steps_per_phase);
    return calc_step_size(pwm_interval, steps_per_phase) * steps_per_phase;
  endfunction

endpackage

// File: rtl/pwm_hue_sequencer_if.sv
// rtl/pwm_hue_sequencer_if.sv - control and colour bundle of the hue sequencer
// Purpose: groups start/pause/stop controls and the r/g/b/phase/busy/wheel_done results.
// Ports: master drives start, pause, stop and observes the results; slave is the sequencer.
interface pwm_hue_sequencer_if #(
  parameter int PWM_INTERVAL = 1000
);
  localparam int W = $clog2(PWM_INTERVAL);

  logic         start;
  logic         pause;
  logic         stop;
  logic [W-1:0] r_value;
  logic [W-1:0] g_value;
  logic [W-1:0] b_value;
  logic [2:0]   phase;
  logic         busy;
  logic         wheel_done;

  modport master (
    output start, pause, stop,
    input  r_value, g_value, b_value, phase, busy, wheel_done
  );

  modport slave (
    input  start, pause, stop,
    output r_value, g_value, b_value, phase, busy, wheel_done
  );
endinterface

// File: rtl/pwm_period_tick.sv
// rtl/pwm_period_tick.sv - free-running pwm period counter with end-of-period tick
// Purpose: counts 0..PWM_INTERVAL-1 forever; tick is high on the last count.
// Ports: clk, rst_n (sync active-low), tick (high while count == PWM_INTERVAL-1).
module pwm_period_tick #(
  parameter int PWM_INTERVAL = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(PWM_INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(PWM_INTERVAL - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tick = (count_q == LAST);
endmodule

// File: rtl/pwm_hue_sequencer.sv
// rtl/pwm_hue_sequencer.sv - sequences r/g/b pwm levels around a 6-phase hue wheel
// Purpose: ramps one channel per phase by STEP_SIZE every UPDATE_PERIODS pwm periods.
// Ports: clk, rst_n (sync active-low), ctrl (slave): start/pause/stop in;
//        r_value/g_value/b_value, phase, busy, wheel_done out (all registered).
module pwm_hue_sequencer
  import pwm_pkg::*;
#(
  parameter int PWM_INTERVAL    = 1000,
  parameter int STEPS_PER_PHASE = 111,
  parameter int UPDATE_PERIODS  = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_hue_sequencer_if.slave ctrl
);
  localparam int W  = $clog2(PWM_INTERVAL);
  localparam int KW = $clog2(STEPS_PER_PHASE + 1);
  localparam int PW = $clog2(UPDATE_PERIODS + 1);
  localparam logic [W-1:0]  STEP      = W'(calc_step_size(PWM_INTERVAL, STEPS_PER_PHASE));
  localparam logic [W-1:0]  LEVEL_MAX = W'(calc_level_max(PWM_INTERVAL, STEPS_PER_PHASE));
  localparam logic [KW-1:0] K_LAST    = KW'(STEPS_PER_PHASE - 1);
  localparam logic [PW-1:0] P_LAST    = PW'(UPDATE_PERIODS - 1);

  if (STEPS_PER_PHASE < 1 || STEPS_PER_PHASE > PWM_INTERVAL - 1) begin : g_bad_steps
    $error("STEPS_PER_PHASE must be in 1..PWM_INTERVAL-1");
  end
  if (UPDATE_PERIODS < 1) begin : g_bad_update
    $error("UPDATE_PERIODS must be at least 1");
  end

  state_t        state_q, state_nx;
  phase_t        phase_q;
  logic [KW-1:0] step_q;
  logic [PW-1:0] per_q;
  logic [W-1:0]  r_q, g_q, b_q;
  logic          wheel_done_q;
  logic          tick;
  logic          count_en;
  logic          advance;

  pwm_period_tick #(.PWM_INTERVAL(PWM_INTERVAL)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // RUN ignores a tick in the same cycle pause rises, so the hold is clean.
  assign count_en = (state_q == RUN) && !ctrl.pause && tick;
  assign advance  = count_en && (per_q == P_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OFF;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    if (ctrl.stop) begin
      state_nx = OFF;
    end else if (ctrl.start) begin
      state_nx = ctrl.pause ? HOLD : RUN;
    end else begin
      case (state_q)
        RUN:     if (ctrl.pause)  state_nx = HOLD;
        HOLD:    if (!ctrl.pause) state_nx = RUN;
        default: state_nx = state_q;
      endcase
    end
  end

  // Only the ramping channel of the current phase moves; stepping it across the
  // phase boundary lands it exactly on LEVEL_MAX or 0, so no separate reload is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      phase_q      <= PH_0;
      step_q       <= '0;
      per_q        <= '0;
      wheel_done_q <= 1'b0;
    end else begin
      wheel_done_q <= 1'b0;
      if (ctrl.stop) begin
        r_q     <= '0;
        g_q     <= '0;
        b_q     <= '0;
        phase_q <= PH_0;
        step_q  <= '0;
        per_q   <= '0;
      end else if (ctrl.start) begin
        r_q     <= LEVEL_MAX;
        g_q     <= '0;
        b_q     <= '0;
        phase_q <= PH_0;
        step_q  <= '0;
        per_q   <= '0;
      end else if (advance) begin
        per_q <= '0;
        case (phase_q)
          PH_0:    g_q <= g_q + STEP;
          PH_1:    r_q <= r_q - STEP;
          PH_2:    b_q <= b_q + STEP;
          PH_3:    g_q <= g_q - STEP;
          PH_4:    r_q <= r_q + STEP;
          default: b_q <= b_q - STEP;
        endcase
        if (step_q == K_LAST) begin
          step_q <= '0;
          if (phase_q == PH_5) begin
            phase_q      <= PH_0;
            wheel_done_q <= 1'b1;
          end else begin
            phase_q <= phase_t'(phase_q + 3'd1);
          end
        end else begin
          step_q <= step_q + KW'(1);
        end
      end else if (count_en) begin
        per_q <= per_q + PW'(1);
      end
    end
  end

  assign ctrl.r_value    = r_q;
  assign ctrl.g_value    = g_q;
  assign ctrl.b_value    = b_q;
  assign ctrl.phase      = phase_q;
  assign ctrl.busy       = (state_q != OFF);
  assign ctrl.wheel_done = wheel_done_q;
endmodule

// File: doc/pwm_hue_sequencer.md
Name: pwm_hue_sequencer

Overview:
Controller that drives three pwm instances (R, G, B) through a continuous hue wheel by sequencing their pwm_value inputs. It advances a 6-phase HSV-style ramp at a rate locked to whole PWM periods. Start, pause and stop controls let top-level logic hold a colour or blank the LED. It sits between the top-level control logic and three pwm instances that share the same PWM_INTERVAL.

Parameters:
PWM_INTERVAL, 1000, clocks per PWM period; must match the driven pwm instances; output width is $clog2(PWM_INTERVAL)
STEPS_PER_PHASE, 111, ramp steps per hue phase; legal range 1..PWM_INTERVAL-1, elaboration error otherwise
UPDATE_PERIODS, 18, whole PWM periods per ramp step; must be >=1 (defaults give ~1.0 s per wheel at 12 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  pulse; begin or restart the wheel at hue 0
pause  in  1  level; freeze the current colour while high
stop  in  1  pulse; blank the outputs and go to OFF
r_value  out  $clog2(PWM_INTERVAL)  pwm_value for the red pwm
g_value  out  $clog2(PWM_INTERVAL)  pwm_value for the green pwm
b_value  out  $clog2(PWM_INTERVAL)  pwm_value for the blue pwm
phase  out  3  current hue phase, 0..5
busy  out  1  high in RUN and HOLD
wheel_done  out  1  one-cycle pulse when phase wraps from 5 to 0

Behaviour:
- Derived constants: STEP_SIZE = (PWM_INTERVAL-1)/STEPS_PER_PHASE (integer division); LEVEL_MAX = STEP_SIZE*STEPS_PER_PHASE.
- Reset (rst_n=0 at posedge): state OFF; all values 0; phase 0; step 0; period counter 0; period-in-step counter 0; wheel_done 0.
- Period counter: free-runs 0..PWM_INTERVAL-1 in every state. tick = (period counter == PWM_INTERVAL-1).
- States:
  - OFF: values 0. A value of 0 still gives a 1-clock high per period in pwm; this is accepted.
  - RUN: advancing.
  - HOLD: frozen.
- Transitions:
  - stop has priority over everything: any state -> OFF, values 0 on the next cycle.
  - start (without stop): any state -> RUN. Load phase 0, step 0, R=LEVEL_MAX, G=0, B=0, period-in-step counter 0. The period counter is not reset.
  - RUN -> HOLD while pause=1; HOLD -> RUN when pause=0.
  - In HOLD the step, phase and period-in-step counters are frozen.
  - pause has no effect in OFF.
- Advance: occurs when state RUN, pause=0, tick=1 and period-in-step == UPDATE_PERIODS-1. Otherwise, on tick in RUN, period-in-step increments.
  - Let k = step, 0..STEPS_PER_PHASE-1. Registered outputs must always equal the table below.
  - Phase 0: R=MAX, G=k*STEP, B=0
  - Phase 1: R=MAX-k*STEP, G=MAX, B=0
  - Phase 2: R=0, G=MAX, B=k*STEP
  - Phase 3: R=0, G=MAX-k*STEP, B=MAX
  - Phase 4: R=k*STEP, G=0, B=MAX
  - Phase 5: R=MAX, G=0, B=MAX-k*STEP
- Ramping is implemented by adding or subtracting STEP_SIZE; no multipliers. The ramping channel lands exactly on LEVEL_MAX or 0 at the phase boundary, so the colour is continuous.
- Step wrap: at k=STEPS_PER_PHASE-1 an advance sets k=0 and phase=phase+1. From phase 5 the phase goes to 0 and wheel_done pulses high in the same cycle the outputs update.
- Latency: all outputs are registered. The effect of start, stop or an advance is visible one cycle after the triggering edge.
- Simultaneous events:
  - start and stop together -> OFF.
  - start with pause=1 -> load hue 0 and enter HOLD.
  - start during an advance cycle -> the start load wins.
- Arithmetic never exceeds LEVEL_MAX <= PWM_INTERVAL-1, so no overflow in the output width.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum (OFF, RUN, HOLD) and phase enum (PH_0..PH_5);
  - a function computing STEP_SIZE and LEVEL_MAX from the parameters.
- Sub-module pwm_period_tick (parameter PWM_INTERVAL; ports clk, rst_n, tick) holds the free-running period counter. Later blocks reuse it for period-aligned updates.

Test Plan:
All tests use PWM_INTERVAL=10, STEPS_PER_PHASE=3, UPDATE_PERIODS=2, giving STEP_SIZE=3, LEVEL_MAX=9, one step per 20 clocks.
1. Reset -> all values 0, phase 0, busy 0, wheel_done 0. Hold rst_n low mid-RUN -> same result on the next edge.
2. start pulse -> next cycle R=9, G=0, B=0, busy=1. After 2 ticks -> G=3, then G=6. Then phase 1 with R=9, G=9.
3. Run a full wheel (360 clocks after start alignment) -> outputs match the table every step. wheel_done pulses exactly once as phase goes 5->0 with R=9, G=0, B=0.
4. pause=1 at phase 2, k=1 (B=3) for 100 clocks -> outputs frozen. Release pause -> the next advance needs 2 fresh ticks, then B=6.
5. stop during RUN -> next cycle all values 0, busy 0. start and stop asserted together -> OFF.
6. start during phase 4 mid-step -> reload to R=9, G=0, B=0. Period counter continuity is checked against an independent model.
